// File: rtl/timer_if.sv
// Bus between the timer and its user: run control in, count and end pulse out.
interface timer_if #(
    parameter int WIDTH = 16
);
    logic [WIDTH-1:0] n_i;
    logic             start_i;
    logic [WIDTH-1:0] curr_time_q;
    logic             curr_end_q;

    // User side: sets the period and run enable, observes the count.
    modport master (
        output n_i,
        output start_i,
        input  curr_time_q,
        input  curr_end_q
    );

    // Timer side: consumes the controls, drives the registered outputs.
    modport slave (
        input  n_i,
        input  start_i,
        output curr_time_q,
        output curr_end_q
    );
endinterface

// File: rtl/timer.sv
// Restartable cycle counter: counts 0..lim-1 while start_i is high and
// emits a one-cycle end pulse on every wrap. Outputs come straight from flops.
module timer #(
    parameter int WIDTH = 16
) (
    input  logic     clk,
    input  logic     rst_n,   // synchronous, active-high despite the name
    timer_if.slave   bus
);

    logic [WIDTH-1:0] curr_time_d, curr_time_q;
    logic             curr_end_d,  curr_end_q;
    logic [WIDTH-1:0] lim_m1;
    logic             term;

    // Terminal test against the live period; n_i of 0 behaves like 1.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        lim_m1 = '0;
        if (bus.n_i != '0) begin
            lim_m1 = bus.n_i - WIDTH'(1);
        end
        // >= rather than == so a period lowered mid-count still wraps promptly.
        term = (curr_time_q >= lim_m1);
    end

    // Next count and end flag: idle clears, terminal wraps with a pulse, else increment.
    always_comb begin
        curr_time_d = '0;
        curr_end_d  = 1'b0;
        if (bus.start_i) begin
            if (term) begin
                curr_end_d = 1'b1;
            end else begin
                curr_time_d = curr_time_q + WIDTH'(1);
            end
        end
    end

    // Output registers with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
        if (rst_n) begin
            curr_time_q <= '0;
            curr_end_q  <= 1'b0;
        end else begin
            curr_time_q <= curr_time_d;
            curr_end_q  <= curr_end_d;
        end
    end

    assign bus.curr_time_q = curr_time_q;
    assign bus.curr_end_q  = curr_end_q;

endmodule

// File: tb/tb_timer.sv
// Self-checking bench for timer: directed scenarios plus randomized runs
// checked against a modulo-arithmetic model of the period.
module tb_timer;

    localparam int WIDTH = 16;

    logic clk = 1'b0;
    logic rst_n;
    int   n_checks = 0;
    int   n_fail   = 0;

    timer_if #(.WIDTH(WIDTH)) tif ();

    timer #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (tif)
    );

    always #5 clk = ~clk;

    // Advance one rising edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b1; tif.start_i = 1'b1; tif.n_i = 16'd20;
        for (int c = 0; c < 3; c++) begin
            tick();
            n_checks++;
            if ({tif.curr_time_q, tif.curr_end_q} !== {16'd0, 1'b0}) begin
                n_fail++;
                $display("FAIL reset cyc%0d: time=%0d end=%0b, want time=0 end=0",
                         c, tif.curr_time_q, tif.curr_end_q);
            end
        end
        rst_n = 1'b0;
    endtask

    task automatic test_idle();
        tif.start_i = 1'b0; tif.n_i = 16'd20;
        for (int c = 0; c < 20; c++) begin
            tick();
            n_checks++;
            if ({tif.curr_time_q, tif.curr_end_q} !== {16'd0, 1'b0}) begin
                n_fail++;
                $display("FAIL idle cyc%0d: time=%0d end=%0b, want time=0 end=0",
                         c, tif.curr_time_q, tif.curr_end_q);
            end
        end
    endtask

    task automatic test_periodic();
        logic [15:0] et;
        logic        ee;
        tif.start_i = 1'b1; tif.n_i = 16'd20;
        for (int c = 1; c <= 50; c++) begin
            tick();
            et = 16'(c % 20);
            ee = (c == 20) || (c == 40);
            n_checks++;
            if ({tif.curr_time_q, tif.curr_end_q} !== {et, ee}) begin
                n_fail++;
                $display("FAIL periodic cyc%0d: time=%0d end=%0b, want time=%0d end=%0b",
                         c, tif.curr_time_q, tif.curr_end_q, et, ee);
            end
        end
    endtask

    task automatic test_abort_restart();
        logic [15:0] et;
        logic        ee;
        tif.n_i = 16'd20;
        tif.start_i = 1'b0; tick();
        tif.start_i = 1'b1;
        for (int c = 1; c <= 7; c++) tick();
        n_checks++;
        if (tif.curr_time_q !== 16'd7) begin
            n_fail++;
            $display("FAIL abort_pre: time=%0d, want 7", tif.curr_time_q);
        end
        tif.start_i = 1'b0; tick();
        n_checks++;
        if ({tif.curr_time_q, tif.curr_end_q} !== {16'd0, 1'b0}) begin
            n_fail++;
            $display("FAIL abort_drop: time=%0d end=%0b, want time=0 end=0",
                     tif.curr_time_q, tif.curr_end_q);
        end
        tif.start_i = 1'b1;
        for (int c = 1; c <= 21; c++) begin
            tick();
            et = 16'(c % 20);
            ee = (c == 20);
            n_checks++;
            if ({tif.curr_time_q, tif.curr_end_q} !== {et, ee}) begin
                n_fail++;
                $display("FAIL restart cyc%0d: time=%0d end=%0b, want time=%0d end=%0b",
                         c, tif.curr_time_q, tif.curr_end_q, et, ee);
            end
        end
    endtask

    task automatic test_degenerate();
        logic [15:0] et;
        logic        ee;
        for (int n = 0; n <= 1; n++) begin
            tif.start_i = 1'b0; tick();
            tif.n_i = 16'(n); tif.start_i = 1'b1;
            for (int c = 1; c <= 5; c++) begin
                tick();
                n_checks++;
                if ({tif.curr_time_q, tif.curr_end_q} !== {16'd0, 1'b1}) begin
                    n_fail++;
                    $display("FAIL degen_n%0d cyc%0d: time=%0d end=%0b, want time=0 end=1",
                             n, c, tif.curr_time_q, tif.curr_end_q);
                end
            end
        end
        tif.start_i = 1'b0; tick();
        tif.n_i = 16'd2; tif.start_i = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            tick();
            et = 16'(c % 2);
            ee = (c % 2) == 0;
            n_checks++;
            if ({tif.curr_time_q, tif.curr_end_q} !== {et, ee}) begin
                n_fail++;
                $display("FAIL degen_n2 cyc%0d: time=%0d end=%0b, want time=%0d end=%0b",
                         c, tif.curr_time_q, tif.curr_end_q, et, ee);
            end
        end
    endtask

    task automatic test_live_change();
        logic [15:0] et;
        logic        ee;
        tif.start_i = 1'b0; tick();
        tif.n_i = 16'd20; tif.start_i = 1'b1;
        for (int c = 1; c <= 15; c++) tick();
        n_checks++;
        if (tif.curr_time_q !== 16'd15) begin
            n_fail++;
            $display("FAIL live_pre: time=%0d, want 15", tif.curr_time_q);
        end
        tif.n_i = 16'd10; tick();
        n_checks++;
        if ({tif.curr_time_q, tif.curr_end_q} !== {16'd0, 1'b1}) begin
            n_fail++;
            $display("FAIL live_wrap: time=%0d end=%0b, want time=0 end=1",
                     tif.curr_time_q, tif.curr_end_q);
        end
        for (int c = 1; c <= 10; c++) begin
            tick();
            et = 16'(c % 10);
            ee = (c == 10);
            n_checks++;
            if ({tif.curr_time_q, tif.curr_end_q} !== {et, ee}) begin
                n_fail++;
                $display("FAIL live_period cyc%0d: time=%0d end=%0b, want time=%0d end=%0b",
                         c, tif.curr_time_q, tif.curr_end_q, et, ee);
            end
        end
    endtask

    task automatic test_reset_mid_count();
        tif.start_i = 1'b0; tick();
        tif.n_i = 16'd20; tif.start_i = 1'b1;
        for (int c = 1; c <= 9; c++) tick();
        rst_n = 1'b1; tick();
        n_checks++;
        if ({tif.curr_time_q, tif.curr_end_q} !== {16'd0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_mid: time=%0d end=%0b, want time=0 end=0",
                     tif.curr_time_q, tif.curr_end_q);
        end
        rst_n = 1'b0; tick();
        n_checks++;
        if ({tif.curr_time_q, tif.curr_end_q} !== {16'd1, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_resume: time=%0d end=%0b, want time=1 end=0",
                     tif.curr_time_q, tif.curr_end_q);
        end
    endtask

    // Random segments: each starts from idle with a fixed period, so the
    // expected count after k running edges is k mod lim, end when that is 0.
    task automatic test_random();
        int n, lim, len;
        logic [15:0] et;
        logic        ee;
        for (int s = 0; s < 40; s++) begin
            n   = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 2) : $urandom_range(3, 40);
            lim = (n == 0) ? 1 : n;
            len = $urandom_range(1, 90);
            tif.start_i = 1'b0; tif.n_i = 16'($urandom);
            tick();
            n_checks++;
            if ({tif.curr_time_q, tif.curr_end_q} !== {16'd0, 1'b0}) begin
                n_fail++;
                $display("FAIL rand_idle seg%0d: time=%0d end=%0b, want time=0 end=0",
                         s, tif.curr_time_q, tif.curr_end_q);
            end
            tif.n_i = 16'(n); tif.start_i = 1'b1;
            for (int k = 1; k <= len; k++) begin
                tick();
                et = 16'(k % lim);
                ee = (k % lim) == 0;
                n_checks++;
                if ({tif.curr_time_q, tif.curr_end_q} !== {et, ee}) begin
                    n_fail++;
                    $display("FAIL rand seg%0d n=%0d k=%0d: time=%0d end=%0b, want time=%0d end=%0b",
                             s, n, k, tif.curr_time_q, tif.curr_end_q, et, ee);
                end
            end
        end
    endtask

    initial begin
        rst_n = 1'b1; tif.start_i = 1'b0; tif.n_i = '0;
        #1;
        test_reset();
        test_idle();
        test_periodic();
        test_abort_restart();
        test_degenerate();
        test_live_change();
        test_reset_mid_count();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/timer.md
# timer

Free-running, restartable cycle counter for the sequential-timer block. While `start_i` is held high it counts clock cycles from 0 up to `n_i-1`. On the terminal count it wraps back to 0 and raises a one-cycle end flag, so it yields one end pulse every `n_i` cycles. Other logic uses it as a periodic tick or a programmable delay.

## Interface
Parameters:
- `WIDTH`, default 16: width of `n_i` and `curr_time_q`.

Ports:
- `clk`, input, 1: single clock, all state updates on the rising edge.
- `rst_n`, input, 1: reset, synchronous and active-high (asserted when 1, sampled on the rising edge of `clk`).
- `n_i`, input, `WIDTH`: period length in cycles; unsigned.
- `start_i`, input, 1: run enable. 1 = count; 0 = clear and hold idle.
- `curr_time_q`, output, `WIDTH`: registered current count.
- `curr_end_q`, output, 1: registered end pulse, high for exactly one cycle per completed period.

## Operation
- All outputs come directly from flops, with no combinational path from inputs to outputs.
- Effective limit `lim = (n_i == 0) ? 1 : n_i`.
- Terminal condition `term = (curr_time_q >= lim - 1)`, compared as unsigned. Using `>=` guarantees recovery if `n_i` is lowered mid-count.
- Per rising edge, in priority order:
  - `rst_n == 1`: `curr_time_q <= 0`, `curr_end_q <= 0`.
  - `start_i == 0`: `curr_time_q <= 0`, `curr_end_q <= 0` (abort or idle).
  - `start_i == 1` and `term`: `curr_time_q <= 0`, `curr_end_q <= 1`.
  - `start_i == 1` and not `term`: `curr_time_q <= curr_time_q + 1`, `curr_end_q <= 0`.
- There is no separate state register. The modes follow from the inputs:
  - IDLE whenever `start_i = 0`.
  - RUN whenever `start_i = 1`.
  - The wrap to 0 doubles as the END event.
- `n_i` is sampled live every cycle. Changing it while running takes effect at the next terminal comparison.
- `n_i == 0` and `n_i == 1` behave identically: `curr_time_q` stays at 0 and `curr_end_q` is high every cycle while running.
- `n_i = 16'hFFFF`: the count reaches 65534, then wraps. There is no overflow path, because the +1 never exceeds `lim - 1`.

## Timing
- Reset values: `curr_time_q = 0`, `curr_end_q = 0`. They are visible the cycle after the reset edge.
- Start latency: on the first edge with `start_i = 1` (from idle at 0), `curr_time_q` becomes 1 (or 0 with an end pulse if `lim = 1`).
- Running sequence for `n_i = N ≥ 2`, starting from idle:
  - `curr_time_q`: 1, 2, …, N-1, 0, 1, … (period N cycles).
  - `curr_end_q`: 1 only in the cycle where `curr_time_q` has just wrapped to 0.
  - First end pulse: N edges after `start_i` rises.
- Dropping `start_i` mid-count: on the next edge both outputs go to 0. Re-asserting it restarts from 0, and partial progress is discarded.
- Simultaneous `rst_n = 1` and `start_i = 1`: reset wins.
- Reset asserted mid-count: the count is cleared on that edge. Counting resumes from 0 on the first edge after `rst_n` returns to 0 with `start_i` still high.
- An end pulse never lasts longer than one cycle unless `lim = 1`.

## Test plan
- Reset: hold `rst_n = 1` for 3 cycles with `start_i = 1`, `n_i = 20` -> `curr_time_q = 0`, `curr_end_q = 0` throughout.
- Idle: `rst_n = 0`, `start_i = 0`, `n_i = 20` for 20 cycles -> `curr_time_q = 0`, `curr_end_q = 0` every cycle.
- Periodic run: `start_i = 1`, `n_i = 20` for 50 cycles -> `curr_time_q` follows 1..19, 0, 1..19, 0, 1..10; `curr_end_q = 1` only at cycles 20 and 40.
- Abort and restart, `n_i = 20`:
  - Run 7 cycles (`curr_time_q = 7`), drop `start_i` for 1 cycle -> outputs 0.
  - Re-assert `start_i` -> counts 1, 2, …, with the first end pulse 20 cycles later.
- Degenerate limits: `n_i = 0` and `n_i = 1` with `start_i = 1` -> `curr_time_q = 0` and `curr_end_q = 1` every cycle. `n_i = 2` -> time 1, 0, 1, 0 with end 0, 1, 0, 1.
- Live limit change: running with `n_i = 20` at `curr_time_q = 15`, set `n_i = 10` -> next edge wraps to 0 with `curr_end_q = 1`, then the period is 10.
